cordic_req_arbiter: RTL and testbench

- Shares one CORDIC sine/cosine engine between N_REQ requesters.
- Arbitrates requests round-robin and latches the winning angle.
- Sequences the engine's CE, which must be low for at least 1 cycle between jobs.
- Captures COS/SIN when DONE is seen and returns them on one response channel tagged with requester ID. Adds a watchdog so a stuck engine cannot hang the system.

---
 rtl/cordic_req_arbiter_pkg.sv | 17 +
 rtl/cordic_req_arbiter_rr_grant.sv | 36 +++
 rtl/cordic_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_cordic_req_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_req_arbiter_pkg.sv
// Shared settings for the CORDIC request arbiter: widths, timeout default and state encoding.
`ifndef P_DATA_WIDTH
`define P_DATA_WIDTH 32
`endif

package cordic_req_arbiter_pkg;

    localparam int unsigned CRA_DATA_WIDTH  = `P_DATA_WIDTH;
    localparam int unsigned CRA_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cordic_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester after ptr_i (modulo N_REQ) wins.
module cordic_req_arbiter_rr_grant #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Search ptr+1, ptr+2, ... wrapping at N_REQ; first set request is granted.
    always_comb begin
        int unsigned cand;
        logic [ID_W-1:0] cand_idx;
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cordic_req_arbiter.sv
// Shares one CORDIC engine among N_REQ requesters: round-robin grant, CE sequencing,
// result capture with requester tag, and a watchdog that turns a stuck engine into an error response.
module cordic_req_arbiter
    import cordic_req_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_WIDTH  = CRA_DATA_WIDTH,
    parameter int unsigned ID_W        = $clog2(N_REQ),
    parameter int unsigned TIMEOUT_CYC = CRA_TIMEOUT_CYC
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_angle_i,
    output logic [N_REQ-1:0]              req_ready_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_cos_o,
    output logic [DATA_WIDTH-1:0]         rsp_sin_o,
    output logic                          rsp_err_o,
    output logic                          cordic_ce_o,
    output logic [DATA_WIDTH-1:0]         cordic_z_o,
    input  logic                          cordic_done_i,
    input  logic [DATA_WIDTH-1:0]         cordic_cos_i,
    input  logic [DATA_WIDTH-1:0]         cordic_sin_i,
    output logic                          busy_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    arb_state_e             state_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [TMR_W-1:0]       timer_q;
    logic                   ce_q;
    logic [DATA_WIDTH-1:0]  z_q;
    logic                   rsp_valid_q;
    logic [ID_W-1:0]        rsp_id_q;
    logic [DATA_WIDTH-1:0]  rsp_cos_q;
    logic [DATA_WIDTH-1:0]  rsp_sin_q;
    logic                   rsp_err_q;

    logic [N_REQ-1:0]       gnt_onehot;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_any;
    logic [DATA_WIDTH-1:0]  win_angle;
    logic                   timeout_hit;

    cordic_req_arbiter_rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt_onehot),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Select the winning requester's angle slice.
    always_comb begin
        win_angle = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                win_angle = req_angle_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    // Job sequencer: IDLE grants, RUN drives CE and waits for DONE or timeout, RESP holds the result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= ID_W'(N_REQ - 1);
            timer_q     <= '0;
            ce_q        <= 1'b0;
            z_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_cos_q   <= '0;
            rsp_sin_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        z_q      <= win_angle;
                        rsp_id_q <= gnt_idx;
                        rr_ptr_q <= gnt_idx;
                        timer_q  <= '0;
                        ce_q     <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    timer_q <= timer_q + 1'b1;
                    if (cordic_done_i) begin
                        rsp_cos_q   <= cordic_cos_i;
                        rsp_sin_q   <= cordic_sin_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        ce_q        <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_cos_q   <= '0;
                        rsp_sin_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        ce_q        <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    ce_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Accept strobe is only offered while idle; grant already implies the request is valid.
    assign req_ready_o = (state_q == ST_IDLE) ? gnt_onehot : '0;
    assign busy_o      = (state_q != ST_IDLE);

    assign cordic_ce_o = ce_q;
    assign cordic_z_o  = z_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_cos_o   = rsp_cos_q;
    assign rsp_sin_o   = rsp_sin_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Bench for cordic_req_arbiter: stub engine, cycle model from the behavioural rules, directed and random traffic.
module tb_cordic_req_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int TO   = 64;
    localparam int P_IT = 30;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_angle;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_cos, rsp_sin;
    logic            rsp_err;
    logic            ce;
    logic [DW-1:0]   z;
    logic            done;
    logic [DW-1:0]   ecos, esin;
    logic            busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b1;

    always #5 clk = ~clk;

    cordic_req_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .ID_W(2), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_angle_i(req_angle), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_cos_o(rsp_cos), .rsp_sin_o(rsp_sin), .rsp_err_o(rsp_err),
        .cordic_ce_o(ce), .cordic_z_o(z), .cordic_done_i(done),
        .cordic_cos_i(ecos), .cordic_sin_i(esin), .busy_o(busy)
    );

    // Stub engine result functions (distinct, easy to hand-compute).
    function automatic logic [DW-1:0] f_cos(input logic [DW-1:0] a);
        return a ^ 32'h4000_0000;
    endfunction
    function automatic logic [DW-1:0] f_sin(input logic [DW-1:0] a);
        return a;
    endfunction

    // Stub engine: loads Z on first CE cycle, DONE on the eng_lat-th CE cycle (0 = never).
    int            eng_lat = P_IT + 3;
    logic          noise = 1'b0;
    int            ecnt;
    logic [DW-1:0] zl;
    logic [DW-1:0] junk = 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt <= 0;
            zl   <= '0;
        end else if (ce) begin
            if (ecnt == 0) zl <= z;
            ecnt <= ecnt + 1;
        end else begin
            ecnt <= 0;
        end
    end

    assign done = ce ? (eng_lat != 0 && ecnt == eng_lat - 1) : noise;
    assign ecos = done ? f_cos(zl) : junk;
    assign esin = done ? f_sin(zl) : ~junk;

    // Behavioural model: phase 0 idle, 1 running, 2 responding.
    int            m_phase = 0;
    int            m_ptr = N - 1;
    int            m_runcnt = 0;
    logic [1:0]    m_id = '0;
    logic [DW-1:0] m_z = '0, m_cos = '0, m_sin = '0;
    logic          m_err = 1'b0, m_valid = 1'b0;
    int            grant_log[$];
    int            pick_now;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always_comb pick_now = rr_pick(req_valid, m_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ptr <= N - 1; m_runcnt <= 0; m_id <= '0;
            m_z <= '0; m_cos <= '0; m_sin <= '0; m_err <= 1'b0; m_valid <= 1'b0;
        end else begin
            case (m_phase)
                0: if (pick_now >= 0) begin
                    m_z      <= req_angle[pick_now*DW +: DW];
                    m_id     <= 2'(pick_now);
                    m_ptr    <= pick_now;
                    m_runcnt <= 0;
                    m_phase  <= 1;
                    grant_log.push_back(pick_now);
                end
                1: begin
                    m_runcnt <= m_runcnt + 1;
                    if (done) begin
                        m_cos <= f_cos(m_z); m_sin <= f_sin(m_z); m_err <= 1'b0;
                        m_valid <= 1'b1; m_phase <= 2;
                    end else if (m_runcnt + 1 == TO) begin
                        m_cos <= '0; m_sin <= '0; m_err <= 1'b1;
                        m_valid <= 1'b1; m_phase <= 2;
                    end
                end
                default: if (rsp_ready) begin
                    m_valid <= 1'b0; m_phase <= 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] exp_rdy;
            exp_rdy = '0;
            if (m_phase == 0 && pick_now >= 0) exp_rdy[pick_now] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("ce", 64'(ce), 64'(m_phase == 1));
            check("busy", 64'(busy), 64'(m_phase != 0));
            check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            check("rsp_id", 64'(rsp_id), 64'(m_id));
            check("rsp_cos", 64'(rsp_cos), 64'(m_cos));
            check("rsp_sin", 64'(rsp_sin), 64'(m_sin));
            check("rsp_err", 64'(rsp_err), 64'(m_err));
            check("cordic_z", 64'(z), 64'(m_z));
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready != '0) return;
        end
        check("wait_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic count_to_rsp(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) return;
        end
        check("wait_rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_grants(input int cnt);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (grant_log.size() >= cnt) return;
        end
        check("wait_grants_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int lat_tab[6] = '{33, 2, 63, 64, 65, 0};

        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ce", 64'(ce), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_z", 64'(z), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin from reset: all four requesting for 8 jobs.
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) req_angle[i*DW +: DW] = $urandom;
        req_valid = 4'hF;
        wait_grants(8);
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) check($sformatf("rr_order_%0d", i), 64'(grant_log[i]), 64'(exp_rr[i]));
            else check($sformatf("rr_order_%0d", i), 64'hFFFF, 64'(exp_rr[i]));
        end
        wait_idle();

        // Single request from requester 2 with angle 0.
        @(posedge clk); #1;
        req_angle[2*DW +: DW] = '0;
        req_valid = 4'b0100;
        wait_ready();
        check("single_ready", 64'(req_ready), 64'h4);
        @(posedge clk); #1;
        req_valid = '0;
        count_to_rsp(n);
        check("single_latency", 64'(n - 1), 64'd33);
        check("single_id", 64'(rsp_id), 64'd2);
        check("single_cos", 64'(rsp_cos), 64'h4000_0000);
        check("single_sin", 64'(rsp_sin), 64'h0);
        check("single_err", 64'(rsp_err), 64'd0);
        wait_idle();

        // Backpressure: hold the response for 20 cycles with requester 1 waiting.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_angle[1*DW +: DW] = 32'h1234_5678;
        req_valid = 4'b0010;
        count_to_rsp(n);
        repeat (20) @(negedge clk);
        check("bp_no_ready", 64'(req_ready), 64'h0);
        check("bp_cos_held", 64'(rsp_cos), 64'(f_cos(32'h1234_5678)));
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_regrant", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Watchdog: engine never finishes.
        eng_lat = 0;
        @(posedge clk); #1;
        req_angle[3*DW +: DW] = 32'h0BAD_F00D;
        req_valid = 4'b1000;
        wait_ready();
        @(posedge clk); #1;
        req_valid = '0;
        count_to_rsp(n);
        check("to_latency", 64'(n), 64'd65);
        check("to_err", 64'(rsp_err), 64'd1);
        check("to_cos", 64'(rsp_cos), 64'h0);
        check("to_sin", 64'(rsp_sin), 64'h0);
        check("to_id", 64'(rsp_id), 64'd3);
        wait_idle();
        eng_lat = P_IT + 3;

        // Large positive / negative angles pass straight through, tagged correctly.
        grant_log.delete();
        @(posedge clk); #1;
        req_angle[1*DW +: DW] = 32'h4000_0000;
        req_angle[3*DW +: DW] = 32'hC000_0000;
        req_valid = 4'b1010;
        count_to_rsp(n);
        check("q2_id", 64'(rsp_id), 64'd1);
        check("q2_cos", 64'(rsp_cos), 64'h0);
        check("q2_sin", 64'(rsp_sin), 64'h4000_0000);
        @(posedge clk); #1;
        count_to_rsp(n);
        check("q3_id", 64'(rsp_id), 64'd3);
        check("q3_cos", 64'(rsp_cos), 64'h8000_0000);
        check("q3_sin", 64'(rsp_sin), 64'hC000_0000);
        req_valid = '0;
        wait_idle();

        // Reset during RUN cycle 10.
        @(posedge clk); #1;
        req_valid = 4'b0100;
        wait_ready();
        @(posedge clk); #1;
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ce", 64'(ce), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_z", 64'(z), 64'd0);
        check("mid_rst_id", 64'(rsp_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        req_valid = 4'hF;
        wait_ready();
        check("post_rst_grant", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Random traffic, random backpressure, random engine latency and spurious DONE.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom) & 4'($urandom | $urandom);
            for (int i = 0; i < N; i++) req_angle[i*DW +: DW] = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            noise = 1'($urandom_range(0, 1));
            junk = $urandom;
            if ($urandom_range(0, 49) == 0) eng_lat = lat_tab[$urandom_range(0, 5)];
        end

        // Drain.
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        noise = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
